// File: rtl/sh_mem_arbiter_pkg.sv
// sh_mem_arbiter_pkg
//   Shared sizes and request codes for the cores, the shared-memory
//   arbiter and the RAM.
//   NUM_OF_CORES : number of requesters
//   REG_SIZE     : data width per core
//   ADDR_SIZE    : word address width (RAM depth 2**ADDR_SIZE)
//   ENABLE_SIZE  : request code width per core
package sh_mem_arbiter_pkg;

    localparam int NUM_OF_CORES = 16;
    localparam int REG_SIZE     = 8;
    localparam int ADDR_SIZE    = 8;
    localparam int ENABLE_SIZE  = 2;

    typedef enum logic [1:0] {
        EN_IDLE  = 2'b00,
        EN_READ  = 2'b01,
        EN_WRITE = 2'b10,
        EN_RSVD  = 2'b11
    } req_code_e;

    // Only read and write are ever granted; reserved behaves as idle.
    function automatic logic req_is_valid(input logic [1:0] code);
        return (code == EN_READ) || (code == EN_WRITE);
    endfunction

endpackage

// File: rtl/sh_mem_arbiter_if.sv
// sh_mem_arbiter_if
//   Bundles the flattened core request buses and the single-port RAM
//   bus seen by the arbiter.
//   enable_arb/addr_arb/wr_data_arb : per-core request (core -> arbiter)
//   rd_data_arb/ready_arb           : per-core response (arbiter -> core)
//   mem_en/mem_we/mem_addr/mem_wdata: RAM strobe bus (arbiter -> RAM)
//   mem_rdata                       : RAM read data, one cycle after a read
//   Modports: slave = arbiter side, master = cores + RAM side.
interface sh_mem_arbiter_if #(
    parameter int NUM_OF_CORES = 16,
    parameter int REG_SIZE     = 8,
    parameter int ADDR_SIZE    = 8,
    parameter int ENABLE_SIZE  = 2
);
    logic [NUM_OF_CORES*ENABLE_SIZE-1:0] enable_arb;
    logic [NUM_OF_CORES*ADDR_SIZE-1:0]   addr_arb;
    logic [NUM_OF_CORES*REG_SIZE-1:0]    wr_data_arb;
    logic [NUM_OF_CORES*REG_SIZE-1:0]    rd_data_arb;
    logic [NUM_OF_CORES-1:0]             ready_arb;
    logic                                mem_en;
    logic                                mem_we;
    logic [ADDR_SIZE-1:0]                mem_addr;
    logic [REG_SIZE-1:0]                 mem_wdata;
    logic [REG_SIZE-1:0]                 mem_rdata;

    modport slave (
        input  enable_arb, addr_arb, wr_data_arb, mem_rdata,
        output rd_data_arb, ready_arb, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output enable_arb, addr_arb, wr_data_arb, mem_rdata,
        input  rd_data_arb, ready_arb, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sh_mem_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin selector: first set request at or after
//   the pointer, wrapping from NUM_REQ-1 to 0.
//   i_req   : request vector
//   i_ptr   : highest-priority index this cycle
//   o_grant : one-hot grant (all zero when nothing requested)
//   o_idx   : encoded winner index (0 when nothing requested)
//   o_any   : a grant was made
module rr_picker #(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int unsigned w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_j = (32'(i_ptr) + off) % 32'(NUM_REQ);
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_idx      = IDX_W'(w_j);
                o_grant[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sh_mem_arbiter.sv
// sh_mem_arbiter
//   Round-robin arbiter sharing one single-port synchronous RAM among
//   all cores. Two-stage pipeline:
//     G: combinational arbitration drives the RAM strobe bus.
//     R: one-cycle ready pulse to the winner; read data is captured into
//        the winner's rd_data slice at the end of this cycle.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : core request/response buses and RAM bus (slave modport)
module sh_mem_arbiter
    import sh_mem_arbiter_pkg::*;
#(
    parameter int NUM_OF_CORES = sh_mem_arbiter_pkg::NUM_OF_CORES,
    parameter int REG_SIZE     = sh_mem_arbiter_pkg::REG_SIZE,
    parameter int ADDR_SIZE    = sh_mem_arbiter_pkg::ADDR_SIZE,
    parameter int ENABLE_SIZE  = sh_mem_arbiter_pkg::ENABLE_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    sh_mem_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_OF_CORES > 1) ? $clog2(NUM_OF_CORES) : 1;

    logic [NUM_OF_CORES-1:0] w_req_elig;
    logic [NUM_OF_CORES-1:0] w_grant;
    logic [IDX_W-1:0]        w_win_idx;
    logic                    w_any;
    logic [ENABLE_SIZE-1:0]  w_win_code;
    logic [ADDR_SIZE-1:0]    w_win_addr;
    logic [REG_SIZE-1:0]     w_win_wdata;

    logic [IDX_W-1:0]                 r_rr_ptr;
    logic                             r_r_valid;
    logic [IDX_W-1:0]                 r_r_idx;
    logic                             r_r_read;
    logic [NUM_OF_CORES-1:0]          r_ready;
    logic [NUM_OF_CORES*REG_SIZE-1:0] r_rd_data;

    // The core in stage R is masked: it still holds its request while it
    // samples ready, so without the mask it would be granted twice.
    always_comb begin
        w_req_elig = '0;
        for (int unsigned i = 0; i < NUM_OF_CORES; i++) begin
            w_req_elig[i] = req_is_valid(bus.enable_arb[i*ENABLE_SIZE +: ENABLE_SIZE])
                         && !(r_r_valid && (r_r_idx == IDX_W'(i)));
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_OF_CORES),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (w_req_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_any   (w_any)
    );

    // One-hot AND-OR mux; with no grant everything falls to zero.
    always_comb begin
        w_win_code  = '0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        for (int unsigned i = 0; i < NUM_OF_CORES; i++) begin
            if (w_grant[i]) begin
                w_win_code  = w_win_code  | bus.enable_arb[i*ENABLE_SIZE +: ENABLE_SIZE];
                w_win_addr  = w_win_addr  | bus.addr_arb[i*ADDR_SIZE +: ADDR_SIZE];
                w_win_wdata = w_win_wdata | bus.wr_data_arb[i*REG_SIZE +: REG_SIZE];
            end
        end
    end

    // Strobes are gated by reset so the RAM sees nothing while it is low.
    assign bus.mem_en    = reset & w_any;
    assign bus.mem_we    = reset & w_any & (w_win_code == EN_WRITE);
    assign bus.mem_addr  = w_win_addr;
    assign bus.mem_wdata = w_win_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr  <= '0;
            r_r_valid <= 1'b0;
            r_r_idx   <= '0;
            r_r_read  <= 1'b0;
            r_ready   <= '0;
        end else begin
            r_r_valid <= w_any;
            r_r_idx   <= w_win_idx;
            r_r_read  <= w_any && (w_win_code == EN_READ);
            r_ready   <= w_grant;
            if (w_any) begin
                r_rr_ptr <= (w_win_idx == IDX_W'(NUM_OF_CORES - 1)) ? '0 : w_win_idx + 1'b1;
            end
        end
    end

    // RAM data arrives during stage R; it is latched at the end of that
    // cycle so the core sees it in its slice from the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_OF_CORES; i++) begin
                if (r_r_valid && r_r_read && (r_r_idx == IDX_W'(i))) begin
                    r_rd_data[i*REG_SIZE +: REG_SIZE] <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.ready_arb   = r_ready;
    assign bus.rd_data_arb = r_rd_data;

endmodule

// File: tb/tb_sh_mem_arbiter.sv
// tb_sh_mem_arbiter
//   Directed stimulus with a scoreboard: each request pushes its expected
//   completion (core, read/write, data); a monitor pops one entry per
//   ready pulse and checks the read slice one cycle later.
module tb_sh_mem_arbiter;
    import sh_mem_arbiter_pkg::*;

    localparam int N  = NUM_OF_CORES;
    localparam int RW = REG_SIZE;
    localparam int AW = ADDR_SIZE;
    localparam int EW = ENABLE_SIZE;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sh_mem_arbiter_if #(
        .NUM_OF_CORES (N),
        .REG_SIZE     (RW),
        .ADDR_SIZE    (AW),
        .ENABLE_SIZE  (EW)
    ) bus ();

    sh_mem_arbiter #(
        .NUM_OF_CORES (N),
        .REG_SIZE     (RW),
        .ADDR_SIZE    (AW),
        .ENABLE_SIZE  (EW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Per-core request registers; one-shot cores drop their request
    // after the cycle in which they saw ready.
    logic [EW-1:0] en[N];
    logic [AW-1:0] ad[N];
    logic [RW-1:0] wd[N];
    bit            oneshot[N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.enable_arb[i*EW +: EW]  = en[i];
            bus.addr_arb[i*AW +: AW]    = ad[i];
            bus.wr_data_arb[i*RW +: RW] = wd[i];
        end
    end

    // Single-port synchronous RAM; unwritten words read as addr ^ 8'h5A.
    logic [RW-1:0] ram[1<<AW];
    bit            ram_wr[1<<AW];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr]    <= bus.mem_wdata;
                ram_wr[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr]
                                                      : (bus.mem_addr ^ 8'h5A);
            end
        end
    end

    typedef struct {
        int unsigned core;
        bit          rd;
        logic [7:0]  data;
    } exp_t;
    exp_t q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_resp(input int unsigned core, input bit rd, input logic [7:0] data);
        exp_t e;
        e.core = core;
        e.rd   = rd;
        e.data = data;
        q.push_back(e);
    endtask

    // Monitor
    initial begin : monitor
        bit          pend_valid;
        int unsigned pend_core;
        logic [7:0]  pend_data;
        exp_t        e;
        pend_valid = 1'b0;
        pend_core  = 0;
        pend_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (pend_valid) begin
                    check($sformatf("rd_data_core%0d", pend_core),
                          32'(bus.rd_data_arb[pend_core*RW +: RW]), 32'(pend_data));
                    pend_valid = 1'b0;
                end
                if (bus.ready_arb != '0) begin
                    if (q.size() == 0) begin
                        check("spurious_ready", 32'(bus.ready_arb), 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("ready_for_core%0d", e.core),
                              32'(bus.ready_arb), 32'(1) << e.core);
                        if (e.rd) begin
                            pend_valid = 1'b1;
                            pend_core  = e.core;
                            pend_data  = e.data;
                        end
                    end
                end
            end
        end
    end

    task automatic req(input int core, input logic [1:0] code, input logic [7:0] a,
                       input logic [7:0] d, input bit os);
        en[core]      = code;
        ad[core]      = a;
        wd[core]      = d;
        oneshot[core] = os;
    endtask

    task automatic tick();
        logic [N-1:0] rdy;
        @(negedge clk);
        rdy = bus.ready_arb;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rdy[i] && oneshot[i]) en[i] = EN_IDLE;
        end
    endtask

    function automatic int unsigned busy_count();
        int unsigned n = 0;
        for (int i = 0; i < N; i++) if (oneshot[i] && en[i] != EN_IDLE) n++;
        return n;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy_count() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("wait_idle_timeout", busy_count(), 0);
        tick();
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset = 1'b0;
        for (int i = 0; i < N; i++) req(i, EN_IDLE, 8'h00, 8'h00, 1'b1);

        // Reset held with core 3 requesting
        req(3, EN_READ, 8'h03, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(bus.ready_arb), 0);
        check("reset_mem_en", 32'(bus.mem_en), 0);
        check("reset_rd_data_any", 32'(|bus.rd_data_arb), 0);
        expect_resp(3, 1'b1, 8'h59);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("first_grant_mem_en", 32'(bus.mem_en), 1);
        check("first_grant_mem_addr", 32'(bus.mem_addr), 32'h03);
        wait_idle();

        // Core 0 write then read back
        req(0, EN_WRITE, 8'h10, 8'hA5, 1'b1);
        expect_resp(0, 1'b0, 8'h00);
        wait_idle();
        req(0, EN_READ, 8'h10, 8'h00, 1'b1);
        expect_resp(0, 1'b1, 8'hA5);
        wait_idle();

        // Core 14 moves the pointer to 15
        req(14, EN_READ, 8'h0E, 8'h00, 1'b1);
        expect_resp(14, 1'b1, 8'h54);
        wait_idle();

        // Cores 15 and 0 with pointer 15: 15 then 0 (wrap), pointer ends at 1
        req(15, EN_READ, 8'h0F, 8'h00, 1'b1);
        req(0,  EN_READ, 8'h30, 8'h00, 1'b1);
        expect_resp(15, 1'b1, 8'h55);
        expect_resp(0,  1'b1, 8'h6A);
        wait_idle();

        // Pointer at 1: core 1 wins over core 0
        req(0, EN_READ, 8'h31, 8'h00, 1'b1);
        req(1, EN_READ, 8'h32, 8'h00, 1'b1);
        expect_resp(1, 1'b1, 8'h68);
        expect_resp(0, 1'b1, 8'h6B);
        wait_idle();

        // Core 15 returns the pointer to 0
        req(15, EN_READ, 8'h40, 8'h00, 1'b1);
        expect_resp(15, 1'b1, 8'h1A);
        wait_idle();

        // Cores 0,1,2 continuous: 0,1,2,0,1,2
        req(0, EN_READ, 8'h20, 8'h00, 1'b0);
        req(1, EN_READ, 8'h21, 8'h00, 1'b0);
        req(2, EN_READ, 8'h22, 8'h00, 1'b0);
        for (int k = 0; k < 2; k++) begin
            expect_resp(0, 1'b1, 8'h7A);
            expect_resp(1, 1'b1, 8'h7B);
            expect_resp(2, 1'b1, 8'h78);
        end
        repeat (6) tick();
        for (int i = 0; i < 3; i++) req(i, EN_IDLE, 8'h00, 8'h00, 1'b1);
        tick();
        tick();

        // Core 5 alone: one access per two cycles
        req(5, EN_READ, 8'h55, 8'h00, 1'b0);
        expect_resp(5, 1'b1, 8'h0F);
        expect_resp(5, 1'b1, 8'h0F);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("solo_mem_en_c%0d", k), 32'(bus.mem_en), (k % 2 == 0) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        req(5, EN_IDLE, 8'h00, 8'h00, 1'b1);
        tick();
        tick();

        // Core 2 writes 0x7F, core 4 reads it in the next cycle
        req(2, EN_WRITE, 8'h7F, 8'h3C, 1'b1);
        req(4, EN_READ,  8'h7F, 8'h00, 1'b1);
        expect_resp(2, 1'b0, 8'h00);
        expect_resp(4, 1'b1, 8'h3C);
        wait_idle();

        // Reserved code on core 7 is never granted
        req(7, EN_RSVD, 8'h07, 8'h00, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("rsvd_mem_en_c%0d", k), 32'(bus.mem_en), 0);
        end
        @(posedge clk);
        #1;
        req(7, EN_IDLE, 8'h00, 8'h00, 1'b1);

        repeat (3) tick();
        check("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
